// File: rtl/branch_checkpoint_table.sv
// Branch checkpoint table: records the ROB tag of each in-flight branch and, on a
// mispredict, restores the tag allocator and squashes younger checkpoints. Optional
// performance counters are enabled with BCT_PERF_EN.
module branch_checkpoint_table #(
    parameter int ROB_BITS   = 4,
    parameter int NUM_CKPT   = 4,
    parameter int BR_ID_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [ROB_BITS-1:0]   alloc_rob_tag,
    output logic [BR_ID_BITS-1:0] alloc_br_id,
    input  logic                  resolve_valid,
    input  logic [BR_ID_BITS-1:0] resolve_br_id,
    input  logic                  resolve_mispredict,
    output logic                  restore_en,
    output logic [ROB_BITS-1:0]   restore_tag,
    output logic [NUM_CKPT-1:0]   flush_mask,
    output logic                  recovering,
    output logic [31:0]           perf_branches,
    output logic [31:0]           perf_mispredicts
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CKPT-1:0]     valid_q, valid_d;
    logic [ROB_BITS-1:0]     tag_q [NUM_CKPT];
    logic [BR_ID_BITS-1:0]   tail_q, tail_d;
    logic                    restore_en_q, restore_en_d;
    logic [ROB_BITS-1:0]     restore_tag_q, restore_tag_d;
    logic [NUM_CKPT-1:0]     flush_mask_q, flush_mask_d;

    logic                    alloc_fire;
    logic                    resolve_hit;
    logic                    mispredict_accept;
    logic                    correct_clear;
    logic [BR_ID_BITS-1:0]   tail_dist;
    logic [BR_ID_BITS-1:0]   slot_dist [NUM_CKPT];
    logic [NUM_CKPT-1:0]     squash_mask;

    assign alloc_ready = !valid_q[tail_q] && (state_q == IDLE)
                         && !(resolve_valid && resolve_mispredict);
    assign alloc_br_id = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;

    assign resolve_hit       = resolve_valid && valid_q[resolve_br_id];
    assign mispredict_accept = resolve_hit && resolve_mispredict && (state_q == IDLE);
    assign correct_clear     = resolve_hit && !resolve_mispredict;

    // Slots from the mispredicted id up to tail-1 are younger. A zero distance with
    // a valid id only happens when the table is full, in which case every slot goes.
    assign tail_dist = tail_q - resolve_br_id;
    generate
        for (genvar gi = 0; gi < NUM_CKPT; gi++) begin : g_squash
            assign slot_dist[gi]   = BR_ID_BITS'(gi) - resolve_br_id;
            assign squash_mask[gi] = (tail_dist == '0) || (slot_dist[gi] < tail_dist);
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        tail_d        = tail_q;
        restore_en_d  = 1'b0;
        restore_tag_d = restore_tag_q;
        flush_mask_d  = '0;
        case (state_q)
            IDLE: begin
                if (mispredict_accept) begin
                    valid_d       = valid_q & ~squash_mask;
                    tail_d        = resolve_br_id;
                    restore_en_d  = 1'b1;
                    restore_tag_d = tag_q[resolve_br_id] + ROB_BITS'(1);
                    flush_mask_d  = squash_mask;
                    state_d       = RECOVER;
                end else begin
                    if (alloc_fire) begin
                        valid_d[tail_q] = 1'b1;
                        tail_d          = tail_q + BR_ID_BITS'(1);
                    end
                    if (correct_clear) begin
                        valid_d[resolve_br_id] = 1'b0;
                    end
                end
            end
            RECOVER: begin
                if (correct_clear) begin
                    valid_d[resolve_br_id] = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            tail_q        <= '0;
            restore_en_q  <= 1'b0;
            restore_tag_q <= '0;
            flush_mask_q  <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            tail_q        <= tail_d;
            restore_en_q  <= restore_en_d;
            restore_tag_q <= restore_tag_d;
            flush_mask_q  <= flush_mask_d;
        end
    end

    // Tag storage is only read behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            tag_q[tail_q] <= alloc_rob_tag;
        end
    end

    assign restore_en  = restore_en_q;
    assign restore_tag = restore_tag_q;
    assign flush_mask  = flush_mask_q;
    assign recovering  = (state_q == RECOVER);

`ifdef BCT_PERF_EN
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispredicts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            if (alloc_fire) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (mispredict_accept) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_checkpoint_table.sv
// Scoreboard bench for branch_checkpoint_table: stimulus queues expected grants and
// restore pulses, a negedge monitor pops and compares them as the DUT presents them.
module tb_branch_checkpoint_table;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_rob_tag;
    logic [1:0]  alloc_br_id;
    logic        resolve_valid;
    logic [1:0]  resolve_br_id;
    logic        resolve_mispredict;
    logic        restore_en;
    logic [3:0]  restore_tag;
    logic [3:0]  flush_mask;
    logic        recovering;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int checks_total  = 0;
    int checks_passed = 0;

    int         exp_alloc_q [$];
    logic [7:0] exp_restore_q [$];   // {restore_tag, flush_mask}

    branch_checkpoint_table dut (
        .clk                (clk),
        .rst                (rst),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_rob_tag      (alloc_rob_tag),
        .alloc_br_id        (alloc_br_id),
        .resolve_valid      (resolve_valid),
        .resolve_br_id      (resolve_br_id),
        .resolve_mispredict (resolve_mispredict),
        .restore_en         (restore_en),
        .restore_tag        (restore_tag),
        .flush_mask         (flush_mask),
        .recovering         (recovering),
        .perf_branches      (perf_branches),
        .perf_mispredicts   (perf_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
            $display("check %s: got %0d ok", name, act);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks_total++;
        $display("FAIL %s: got an output with nothing expected", name);
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (alloc_valid && alloc_ready) begin
            if (exp_alloc_q.size() == 0) begin
                note_fail("unexpected_alloc");
            end else begin
                chk("alloc_br_id", 32'(alloc_br_id), 32'(exp_alloc_q.pop_front()));
            end
        end
        if (restore_en) begin
            if (exp_restore_q.size() == 0) begin
                note_fail("unexpected_restore");
            end else begin
                logic [7:0] e;
                e = exp_restore_q.pop_front();
                chk("restore_tag", 32'(restore_tag), 32'(e[7:4]));
                chk("flush_mask", 32'(flush_mask), 32'(e[3:0]));
                chk("recovering_with_restore", 32'(recovering), 32'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid        = 1'b0;
        alloc_rob_tag      = '0;
        resolve_valid      = 1'b0;
        resolve_br_id      = '0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] tag, input int exp_id);
        alloc_valid   = 1'b1;
        alloc_rob_tag = tag;
        exp_alloc_q.push_back(exp_id);
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] id, input logic mis);
        resolve_valid      = 1'b1;
        resolve_br_id      = id;
        resolve_mispredict = mis;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        do_reset();
        #1;
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_br_id", 32'(alloc_br_id), 32'd0);
        chk("reset_restore_en", 32'(restore_en), 32'd0);
        chk("reset_restore_tag", 32'(restore_tag), 32'd0);
        chk("reset_flush_mask", 32'(flush_mask), 32'd0);
        chk("reset_recovering", 32'(recovering), 32'd0);
        chk("reset_perf_br", perf_branches, 32'd0);
        chk("reset_perf_mis", perf_mispredicts, 32'd0);

        // Fill the table with tags 3..6.
        alloc(4'd3, 0);
        alloc(4'd4, 1);
        alloc(4'd5, 2);
        alloc(4'd6, 3);
        #1;
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);

        // Out-of-order correct resolve does not free the tail slot.
        resolve(2'd1, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("ooo_resolve_ready", 32'(alloc_ready), 32'd0);
        resolve(2'd0, 1'b0);
        step();
        idle_inputs();
        #1;
        chk("tail_freed_ready", 32'(alloc_ready), 32'd1);
        alloc(4'd9, 0);

        // Mispredict id1 in a full table holding tags 14,15,0,1.
        do_reset();
        alloc(4'd14, 0);
        alloc(4'd15, 1);
        alloc(4'd0, 2);
        alloc(4'd1, 3);
        resolve(2'd1, 1'b1);
        exp_restore_q.push_back({4'd0, 4'b1110});
        #1;
        chk("mispredict_blocks_ready", 32'(alloc_ready), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("recover_recovering", 32'(recovering), 32'd1);
        chk("recover_restore_en", 32'(restore_en), 32'd1);
        chk("recover_ready", 32'(alloc_ready), 32'd0);
        step();
        chk("post_recover_recovering", 32'(recovering), 32'd0);
        chk("post_recover_restore_en", 32'(restore_en), 32'd0);
        chk("post_recover_flush", 32'(flush_mask), 32'd0);
        chk("post_recover_ready", 32'(alloc_ready), 32'd1);
        chk("post_recover_tail", 32'(alloc_br_id), 32'd1);

        // Mispredict id2 alongside an alloc request; second mispredict in RECOVER.
        alloc(4'd5, 1);
        alloc(4'd6, 2);
        alloc_valid   = 1'b1;
        alloc_rob_tag = 4'd9;
        resolve(2'd2, 1'b1);
        exp_restore_q.push_back({4'd7, 4'b0100});
        #1;
        chk("alloc_vs_mispredict_ready", 32'(alloc_ready), 32'd0);
        step();
        resolve(2'd0, 1'b1);
        #1;
        chk("recover2_ready", 32'(alloc_ready), 32'd0);
        step();
        idle_inputs();
        #1;
        chk("ignored_mis_restore_en", 32'(restore_en), 32'd0);
        chk("restore_tag_holds", 32'(restore_tag), 32'd7);
        chk("tail_after_id2", 32'(alloc_br_id), 32'd2);
        chk("ready_after_id2", 32'(alloc_ready), 32'd1);

        // Resolve of an invalid slot, then reset during RECOVER.
        resolve(2'd3, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("invalid_resolve_recovering", 32'(recovering), 32'd0);
        chk("invalid_resolve_tail", 32'(alloc_br_id), 32'd2);
        resolve(2'd0, 1'b1);
        exp_restore_q.push_back({4'd15, 4'b0011});
        step();
        idle_inputs();
        #1;
        chk("pre_reset_recovering", 32'(recovering), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_in_recover_restore_en", 32'(restore_en), 32'd0);
        chk("rst_in_recover_recovering", 32'(recovering), 32'd0);
        chk("rst_in_recover_tag", 32'(restore_tag), 32'd0);
        chk("rst_in_recover_flush", 32'(flush_mask), 32'd0);
        chk("rst_in_recover_tail", 32'(alloc_br_id), 32'd0);
        rst = 1'b0;
        step();

        // Performance counters: 5 allocations, 2 accepted mispredicts.
        alloc(4'd1, 0);
        alloc(4'd2, 1);
        alloc(4'd3, 2);
        alloc(4'd4, 3);
        resolve(2'd3, 1'b1);
        exp_restore_q.push_back({4'd5, 4'b1000});
        step();
        resolve(2'd2, 1'b0);
        step();
        idle_inputs();
        alloc(4'd8, 3);
        resolve(2'd2, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("full_after_wrap_ready", 32'(alloc_ready), 32'd0);
        resolve(2'd0, 1'b1);
        exp_restore_q.push_back({4'd2, 4'b1111});
        step();
        idle_inputs();
        step();
        chk("all_flushed_ready", 32'(alloc_ready), 32'd1);
        chk("all_flushed_tail", 32'(alloc_br_id), 32'd0);
`ifdef BCT_PERF_EN
        chk("perf_branches", perf_branches, 32'd5);
        chk("perf_mispredicts", perf_mispredicts, 32'd2);
`else
        chk("perf_branches", perf_branches, 32'd0);
        chk("perf_mispredicts", perf_mispredicts, 32'd0);
`endif

        step();
        step();
        chk("pending_allocs", 32'(exp_alloc_q.size()), 32'd0);
        chk("pending_restores", 32'(exp_restore_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
